// File: rtl/arb4_gea0_pkg.sv
// Shared definitions for the gea0 arbiter family: FSM state encodings
// and the default tenure-limit parameters.
package arb4_gea0_pkg;

    // Arbiter state: IDLE arbitrates, GRANT holds the current owner.
    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    // Default tenure limit (cycles) and tenure counter width.
    localparam int HOLD_MAX_DEF = 16;
    localparam int CW_DEF       = 8;

endpackage

// File: rtl/prio_rr_gea0.sv
// Combinational rotating priority encoder. Searches req starting at
// index ptr, wrapping modulo N, and returns the first set bit as a
// one-hot select and as an index. any is the OR of all request bits.
module prio_rr_gea0 #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  sel,
    output logic [IW-1:0] sel_id,
    output logic          any
);

    logic [2*N-1:0] req_dbl;
    logic [2*N-1:0] req_rot;
    logic [IW-1:0]  off;
    logic           found;
    logic [IW:0]    sum;

    // Rotate the request vector so that bit 0 is the highest-priority slot.
    always_comb begin
        req_dbl = {req, req};
        req_rot = req_dbl >> ptr;
    end

    // First set bit of the rotated vector, mapped back to an absolute index.
    always_comb begin
        off    = '0;
        found  = 1'b0;
        sum    = '0;
        sel_id = '0;
        sel    = '0;
        any    = |req;
        for (int i = 0; i < N; i++) begin
            if (!found && req_rot[i]) begin
                found = 1'b1;
                off   = IW'(i);
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= (IW+1)'(N)) begin
            sum = sum - (IW+1)'(N);
        end
        if (found) begin
            sel_id = sum[IW-1:0];
            sel    = N'(1) << sel_id;
        end
    end

endmodule

// File: rtl/arb4_gea0.sv
// Round-robin arbiter with tenure limit. Grants one requester at a time,
// holds the grant until the owner drops req or the tenure limit expires,
// then rotates priority to the requester after the owner. Every handoff
// passes through one IDLE cycle with no grant, so grants never overlap.
module arb4_gea0
    import arb4_gea0_pkg::*;
#(
    parameter int N        = 4,
    parameter int IW       = 2,
    parameter int CW       = CW_DEF,
    parameter int HOLD_MAX = HOLD_MAX_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_id,
    output logic          busy,
    output logic          timeout
);

    // Count value at which the owner has used its last allowed cycle.
    localparam logic [CW-1:0] LIMIT    = (HOLD_MAX == 0) ? '0 : CW'(HOLD_MAX - 1);
    localparam bit            LIMIT_EN = (HOLD_MAX != 0);

    arb_state_t    state_r, state_nx;
    logic [IW-1:0] ptr_r, ptr_nx;
    logic [CW-1:0] cnt_r, cnt_nx;
    logic [N-1:0]  gnt_r, gnt_nx;
    logic [IW-1:0] gnt_id_r, gnt_id_nx;
    logic          busy_r, busy_nx;
    logic          timeout_r, timeout_nx;

    logic [N-1:0]  sel;
    logic [IW-1:0] sel_id;
    logic          any;
    logic          own_req;
    logic [IW-1:0] ptr_after;

    prio_rr_gea0 #(
        .N  (N),
        .IW (IW)
    ) u_prio (
        .req    (req),
        .ptr    (ptr_r),
        .sel    (sel),
        .sel_id (sel_id),
        .any    (any)
    );

    // Owner still requesting, and the slot just after the owner for rotation.
    always_comb begin
        own_req   = |(req & gnt_r);
        ptr_after = (gnt_id_r == IW'(N - 1)) ? '0 : gnt_id_r + IW'(1);
    end

    // Next-state and next-output logic; release has precedence over timeout.
    always_comb begin
        state_nx   = state_r;
        ptr_nx     = ptr_r;
        cnt_nx     = cnt_r;
        gnt_nx     = gnt_r;
        gnt_id_nx  = gnt_id_r;
        busy_nx    = busy_r;
        timeout_nx = 1'b0;
        unique case (state_r)
            ARB_IDLE: begin
                if (any) begin
                    gnt_nx    = sel;
                    gnt_id_nx = sel_id;
                    busy_nx   = 1'b1;
                    cnt_nx    = '0;
                    state_nx  = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                if (!own_req) begin
                    gnt_nx   = '0;
                    busy_nx  = 1'b0;
                    ptr_nx   = ptr_after;
                    cnt_nx   = '0;
                    state_nx = ARB_IDLE;
                end else if (LIMIT_EN && (cnt_r == LIMIT)) begin
                    gnt_nx     = '0;
                    busy_nx    = 1'b0;
                    ptr_nx     = ptr_after;
                    cnt_nx     = '0;
                    timeout_nx = 1'b1;
                    state_nx   = ARB_IDLE;
                end else if (!LIMIT_EN) begin
                    cnt_nx = '0;
                end else if (cnt_r != '1) begin
                    cnt_nx = cnt_r + CW'(1);
                end
            end
            default: begin
                state_nx = ARB_IDLE;
                gnt_nx   = '0;
                busy_nx  = 1'b0;
            end
        endcase
    end

    // State, pointer, counter and output registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ARB_IDLE;
            ptr_r     <= '0;
            cnt_r     <= '0;
            gnt_r     <= '0;
            gnt_id_r  <= '0;
            busy_r    <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            state_r   <= state_nx;
            ptr_r     <= ptr_nx;
            cnt_r     <= cnt_nx;
            gnt_r     <= gnt_nx;
            gnt_id_r  <= gnt_id_nx;
            busy_r    <= busy_nx;
            timeout_r <= timeout_nx;
        end
    end

    assign gnt     = gnt_r;
    assign gnt_id  = gnt_id_r;
    assign busy    = busy_r;
    assign timeout = timeout_r;

endmodule
